// File: rtl/csa_tree_pkg.sv
// csa_tree_pkg
// Shared constants and elaboration-time helpers for the pipelined carry-save
// reduction tree: the Dadda height sequence, the number of 3:2 levels needed
// for a given row count, and the number of pipeline stages for a register
// spacing.
package csa_tree_pkg;

    localparam int MAX_PP = 16;

    // Dadda heights 2, 3, 4, 6, 9, 13, 19: each is floor(1.5 * previous).
    function automatic int dadda_height(input int j);
        int d;
        d = 2;
        for (int i = 0; i < j; i++) begin
            d = (d * 3) / 2;
        end
        return d;
    endfunction

    // Smallest level count whose starting Dadda height covers n rows.
    function automatic int dadda_levels(input int n);
        int l;
        l = 0;
        for (int j = 7; j >= 0; j--) begin
            if (dadda_height(j) >= n) begin
                l = j;
            end
        end
        return l;
    endfunction

    // One register per reg_every levels, and always at least the output register.
    function automatic int tree_stages(input int levels, input int reg_every);
        int r;
        int s;
        r = (reg_every < 1) ? 1 : reg_every;
        s = (levels + r - 1) / r;
        return (s < 1) ? 1 : s;
    endfunction

    // Number of rows entering level l (level 'levels' is the final two rows).
    function automatic int level_height(input int num_pp, input int levels, input int l);
        return (l == 0) ? num_pp : dadda_height(levels - l);
    endfunction

endpackage

// File: rtl/csa_3to2.sv
// csa_3to2
// Row-wide array of full adders compressing three rows into a sum row and a
// carry row. The carry row is moved to its true weight; the carry out of the
// MSB is dropped, since all arithmetic is modulo 2^W.
// Ports:
//   a, b, c    : input rows, W bits each
//   s          : bitwise sum row
//   c_shifted  : majority row shifted left by one, bit 0 is always 0
module csa_3to2 #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] s,
    output logic [W-1:0] c_shifted
);

    // The MSB majority would be shifted out, so it is never formed.
    logic [W-2:0] maj;

    assign s         = a ^ b ^ c;
    assign maj       = (a[W-2:0] & b[W-2:0]) | (a[W-2:0] & c[W-2:0]) | (b[W-2:0] & c[W-2:0]);
    assign c_shifted = {maj, 1'b0};

endmodule

// File: rtl/pipelined_csa_tree.sv
// pipelined_csa_tree
// Dadda-scheduled carry-save reduction of NUM_PP rows to one sum row and one
// carry row, with a pipeline register after every REG_EVERY levels and a
// valid/ready handshake with full backpressure. A sideband tag travels with
// each operand set.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid, in_ready            : input handshake
//   partial_products              : NUM_PP rows, row k at [k*PP_WIDTH +: PP_WIDTH]
//   tag_in                        : sideband accompanying the input set
//   out_valid, out_ready          : output handshake
//   sum_out, carry_out, tag_out   : registered carry-save result and its tag
module pipelined_csa_tree
    import csa_tree_pkg::*;
#(
    parameter int PP_WIDTH  = 16,
    parameter int NUM_PP    = 4,
    parameter int REG_EVERY = 1,
    parameter int TAG_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_PP*PP_WIDTH-1:0] partial_products,
    input  logic [TAG_WIDTH-1:0]       tag_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PP_WIDTH-1:0]        sum_out,
    output logic [PP_WIDTH-1:0]        carry_out,
    output logic [TAG_WIDTH-1:0]       tag_out
);

    localparam int W      = PP_WIDTH;
    localparam int LEVELS = dadda_levels(NUM_PP);
    localparam int STAGES = tree_stages(LEVELS, REG_EVERY);

    if (NUM_PP < 2 || NUM_PP > MAX_PP || REG_EVERY < 1) begin : g_bad_cfg
        $error("pipelined_csa_tree: NUM_PP must be 2..16 and REG_EVERY at least 1");
    end

    logic [STAGES-1:0] stg_valid;
    logic [STAGES-1:0] rdy;

    // Ready chain: a stage can load when it is empty or its successor can load,
    // so bubbles collapse and out_ready reaches in_ready combinationally.
    always_comb begin
        logic chain;
        chain = out_ready;
        rdy   = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            chain  = !stg_valid[k] || chain;
            rdy[k] = chain;
        end
    end

    assign in_ready = rdy[0];

    // Reduction levels. Level l takes its rows from the input, from the stage
    // register closing the previous group of REG_EVERY levels, or directly from
    // the previous level.
    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int H_IN  = level_height(NUM_PP, LEVELS, l);
        localparam int H_OUT = level_height(NUM_PP, LEVELS, l + 1);
        localparam int N_CSA = H_IN - H_OUT;

        logic [H_IN*W-1:0]  rin;
        logic [H_OUT*W-1:0] rout;

        if (l == 0) begin : g_from_input
            assign rin = partial_products;
        end else if (l % REG_EVERY == 0) begin : g_from_reg
            assign rin = g_stg[l/REG_EVERY - 1].rows;
        end else begin : g_from_level
            assign rin = g_lvl[l-1].rout;
        end

        // Each adder removes one row; leftover rows pass straight through.
        for (genvar j = 0; j < N_CSA; j++) begin : g_csa
            csa_3to2 #(.W(W)) u_csa (
                .a        (rin[(3*j)*W   +: W]),
                .b        (rin[(3*j+1)*W +: W]),
                .c        (rin[(3*j+2)*W +: W]),
                .s        (rout[(2*j)*W   +: W]),
                .c_shifted(rout[(2*j+1)*W +: W])
            );
        end

        if (H_IN > 3 * N_CSA) begin : g_pass
            assign rout[H_OUT*W-1 : 2*N_CSA*W] = rin[H_IN*W-1 : 3*N_CSA*W];
        end
    end

    // Pipeline stages. Stage k registers the rows after level LAST.
    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LAST = ((k + 1) * REG_EVERY < LEVELS) ? (k + 1) * REG_EVERY : LEVELS;
        localparam int H    = level_height(NUM_PP, LEVELS, LAST);

        logic [H*W-1:0]         rows;
        logic [H*W-1:0]         rows_next;
        logic                   valid;
        logic [TAG_WIDTH-1:0]   tag;
        logic                   up_valid;
        logic [TAG_WIDTH-1:0]   up_tag;

        if (LEVELS == 0) begin : g_direct
            // Two rows need no reduction, but a half-adder pass keeps the
            // carry row's bit 0 at zero like every other configuration.
            csa_3to2 #(.W(W)) u_half (
                .a        (partial_products[W-1:0]),
                .b        (partial_products[2*W-1:W]),
                .c        ('0),
                .s        (rows_next[W-1:0]),
                .c_shifted(rows_next[2*W-1:W])
            );
        end else begin : g_tree
            assign rows_next = g_lvl[LAST-1].rout;
        end

        if (k == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_tag   = tag_in;
        end else begin : g_body
            assign up_valid = stg_valid[k-1];
            assign up_tag   = g_stg[k-1].tag;
        end

        // NOTE: non-blocking assignments so every stage samples its upstream
        // values from before the edge.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid <= 1'b0;
                rows  <= '0;
                tag   <= '0;
            end else if (rdy[k]) begin
                valid <= up_valid;
                if (up_valid) begin
                    rows <= rows_next;
                    tag  <= up_tag;
                end
            end
        end

        assign stg_valid[k] = valid;
    end

    assign out_valid = stg_valid[STAGES-1];
    assign sum_out   = g_stg[STAGES-1].rows[W-1:0];
    assign carry_out = g_stg[STAGES-1].rows[2*W-1:W];
    assign tag_out   = g_stg[STAGES-1].tag;

endmodule

// File: tb/tb_pipelined_csa_tree.sv
// tb_pipelined_csa_tree
// Self-checking bench: default configuration (4 rows, 2 stages) driven with a
// table of hand-computed vectors, backpressure, streaming and mid-stream reset
// sequences; plus an 8-row REG_EVERY=3 instance and a 2-row instance checked
// for latency and the carry-save invariant over random sets.
module tb_pipelined_csa_tree;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default configuration
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] pp = '0;
    logic [3:0]  tag_in = '0;
    logic [15:0] sum_out, carry_out;
    logic [3:0]  tag_out;

    // NUM_PP=8, REG_EVERY=3
    logic         b_in_valid = 1'b0;
    logic         b_in_ready;
    logic         b_out_valid;
    logic         b_out_ready = 1'b1;
    logic [127:0] b_pp = '0;
    logic [3:0]   b_tag = '0;
    logic [15:0]  b_sum, b_carry;
    logic [3:0]   b_tag_out;

    // NUM_PP=2
    logic        c_in_valid = 1'b0;
    logic        c_in_ready;
    logic        c_out_valid;
    logic        c_out_ready = 1'b1;
    logic [31:0] c_pp = '0;
    logic [3:0]  c_tag = '0;
    logic [15:0] c_sum, c_carry;
    logic [3:0]  c_tag_out;

    pipelined_csa_tree dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .partial_products(pp), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum_out(sum_out), .carry_out(carry_out), .tag_out(tag_out)
    );

    pipelined_csa_tree #(.PP_WIDTH(16), .NUM_PP(8), .REG_EVERY(3), .TAG_WIDTH(4)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .partial_products(b_pp), .tag_in(b_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .sum_out(b_sum), .carry_out(b_carry), .tag_out(b_tag_out)
    );

    pipelined_csa_tree #(.PP_WIDTH(16), .NUM_PP(2), .REG_EVERY(1), .TAG_WIDTH(4)) dut_c (
        .clk(clk), .rst(rst),
        .in_valid(c_in_valid), .in_ready(c_in_ready),
        .partial_products(c_pp), .tag_in(c_tag),
        .out_valid(c_out_valid), .out_ready(c_out_ready),
        .sum_out(c_sum), .carry_out(c_carry), .tag_out(c_tag_out)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic missing_expect(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: output with no outstanding input set (t=%0t)", name, $time);
    endtask

    function automatic logic [15:0] row_sum(input logic [255:0] p, input int n);
        logic [15:0] t;
        t = '0;
        for (int i = 0; i < n; i++) t = t + p[i*16 +: 16];
        return t;
    endfunction

    function automatic logic [15:0] tot(input logic [15:0] s, input logic [15:0] c);
        return s + c;
    endfunction

    // Scoreboards
    logic [15:0] exp_q[$];
    logic [3:0]  tag_q[$];
    logic [15:0] bq[$];
    logic [15:0] cq[$];
    int n_acc = 0, n_out = 0, nb_out = 0, nc_out = 0;

    // Called at a falling edge with inputs set: records the transfers that the
    // coming rising edge performs, then advances to the next falling edge.
    task automatic tick();
        logic [15:0] e;
        logic [3:0]  t;
        #1;
        if (!rst && in_valid && in_ready) begin
            exp_q.push_back(row_sum({192'b0, pp}, 4));
            tag_q.push_back(tag_in);
            n_acc++;
        end
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) missing_expect("sb_out");
            else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check("sb_sum", tot(sum_out, carry_out), e);
                check("sb_tag", tag_out, t);
                check("sb_carry_lsb", carry_out[0], 1'b0);
            end
            n_out++;
        end
        @(negedge clk);
    endtask

    task automatic tick_bc();
        logic [15:0] e;
        #1;
        if (!rst && b_in_valid && b_in_ready) bq.push_back(row_sum({128'b0, b_pp}, 8));
        if (!rst && c_in_valid && c_in_ready) cq.push_back(row_sum({224'b0, c_pp}, 2));
        if (!rst && b_out_valid && b_out_ready) begin
            if (bq.size() == 0) missing_expect("cfg8_out");
            else begin
                e = bq.pop_front();
                check("cfg8_sum", tot(b_sum, b_carry), e);
            end
            nb_out++;
        end
        if (!rst && c_out_valid && c_out_ready) begin
            if (cq.size() == 0) missing_expect("cfg2_out");
            else begin
                e = cq.pop_front();
                check("cfg2_sum", tot(c_sum, c_carry), e);
                check("cfg2_carry_lsb", c_carry[0], 1'b0);
            end
            nc_out++;
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic [63:0] rows;
        logic [3:0]  tag;
        logic [15:0] total;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base_acc, base_out, next, budget;
        logic [15:0] snap_sum, snap_carry;
        logic [3:0]  snap_tag;

        vecs[0] = '{64'h0008_0004_0002_0001, 4'h5, 16'h000F};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 4'hA, 16'hFFFC};
        vecs[2] = '{64'h0000_0000_0000_0000, 4'h0, 16'h0000};
        vecs[3] = '{64'h8000_8000_8000_8000, 4'h3, 16'h0000};
        vecs[4] = '{64'hF0F0_0F0F_4321_1234, 4'h6, 16'h5554};
        vecs[5] = '{64'h0000_0001_5555_AAAA, 4'hF, 16'h0000};
        vecs[6] = '{64'h1234_5678_9ABC_DEF0, 4'h9, 16'hE258};

        // Reset and post-reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum", sum_out, 16'h0);
        check("rst_carry", carry_out, 16'h0);
        check("rst_tag", tag_out, 4'h0);
        check("rst_in_ready", in_ready, 1'b1);

        // Table-driven single-set vectors: latency 2, value, tag, carry bit 0
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            pp = vecs[i].rows;
            tag_in = vecs[i].tag;
            in_valid = 1'b1;
            #1 check("vec_accept", in_ready, 1'b1);
            @(negedge clk);
            in_valid = 1'b0;
            pp = '1;
            check("vec_not_early", out_valid, 1'b0);
            @(negedge clk);
            check("vec_valid", out_valid, 1'b1);
            check("vec_total", tot(sum_out, carry_out), vecs[i].total);
            check("vec_tag", tag_out, vecs[i].tag);
            check("vec_carry_lsb", carry_out[0], 1'b0);
            @(negedge clk);
        end

        // Backpressure: six sets offered while the output is stalled
        out_ready = 1'b0;
        base_acc = n_acc;
        base_out = n_out;
        next = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            tag_in = next[3:0];
            pp = {$urandom, $urandom};
            tick();
            if (n_acc - base_acc > next) next++;
            if (c == 2) begin
                snap_sum = sum_out;
                snap_carry = carry_out;
                snap_tag = tag_out;
            end
        end
        check("bp_accepted", n_acc - base_acc, 2);
        #1 check("bp_in_ready_low", in_ready, 1'b0);
        check("bp_out_valid", out_valid, 1'b1);
        check("bp_hold_sum", sum_out, snap_sum);
        check("bp_hold_carry", carry_out, snap_carry);
        check("bp_hold_tag", tag_out, snap_tag);
        out_ready = 1'b1;
        budget = 0;
        while (n_out - base_out < 6 && budget < 40) begin
            in_valid = (next < 6);
            tag_in = next[3:0];
            if (next < 6 && n_acc - base_acc == next) pp = {$urandom, $urandom};
            tick();
            if (n_acc - base_acc > next) next++;
            budget++;
        end
        in_valid = 1'b0;
        check("bp_outputs", n_out - base_out, 6);
        check("bp_all_accepted", next, 6);
        check("bp_queue_empty", exp_q.size(), 0);

        // Continuous stream: one result per cycle after the two-cycle fill
        base_acc = n_acc;
        base_out = n_out;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            pp = {$urandom, $urandom};
            tag_in = i[3:0];
            tick();
        end
        check("stream_accepted", n_acc - base_acc, 100);
        check("stream_rate", n_out - base_out, 98);
        in_valid = 1'b0;
        repeat (2) tick();
        check("stream_drained", n_out - base_out, 100);

        // Reset with two sets in flight
        in_valid = 1'b1;
        pp = {$urandom, $urandom};
        tag_in = 4'hA;
        tick();
        pp = {$urandom, $urandom};
        tag_in = 4'hB;
        tick();
        check("rst_mid_full", out_valid, 1'b1);
        rst = 1'b1;
        tag_in = 4'hD;
        tick();
        exp_q.delete();
        tag_q.delete();
        check("rst_mid_out_valid", out_valid, 1'b0);
        check("rst_mid_sum", sum_out, 16'h0);
        check("rst_mid_carry", carry_out, 16'h0);
        check("rst_mid_tag", tag_out, 4'h0);
        rst = 1'b0;
        base_out = n_out;
        pp = {$urandom, $urandom};
        tag_in = 4'hC;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        budget = 0;
        while (n_out == base_out && budget < 10) begin
            tick();
            budget++;
        end
        check("rst_mid_recovered", n_out - base_out, 1);

        // Other configurations: latency 2 (8 rows, REG_EVERY=3) and 1 (2 rows)
        for (int i = 0; i < 502; i++) begin
            if (i == 0) check("cfg2_idle", c_out_valid, 1'b0);
            if (i == 1) begin
                check("cfg2_latency", c_out_valid, 1'b1);
                check("cfg8_not_early", b_out_valid, 1'b0);
            end
            if (i == 2) check("cfg8_latency", b_out_valid, 1'b1);
            b_in_valid = (i < 500);
            c_in_valid = (i < 500);
            b_pp = {$urandom, $urandom, $urandom, $urandom};
            c_pp = $urandom;
            b_tag = i[3:0];
            c_tag = i[3:0];
            tick_bc();
        end
        b_in_valid = 1'b0;
        c_in_valid = 1'b0;
        check("cfg8_count", nb_out, 500);
        check("cfg2_count", nc_out, 500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_csa_tree.md
# pipelined_csa_tree

Parametrised, pipelined carry-save reduction tree that compresses NUM_PP partial-product rows of PP_WIDTH bits into one sum row and one carry row. A sideband tag travels with each operand set. It is the next generation of the fixed four-row, purely combinational reducer, and sits between the radix-4 Booth partial-product generator and the hybrid final adder. Registers are inserted at a configurable spacing, and a valid/ready handshake provides full backpressure.

## Interface
- PP_WIDTH, 16: width of each partial-product row and of both outputs.
- NUM_PP, 4: number of input rows; legal range 2..16.
- REG_EVERY, 1: number of 3:2 CSA levels between pipeline registers; must be at least 1.
- TAG_WIDTH, 4: width of the sideband tag carried alongside the data.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  input operand set is valid.
- in_ready  out  1  the block accepts the set this cycle.
- partial_products  in  NUM_PP*PP_WIDTH  row k occupies bits [k*PP_WIDTH +: PP_WIDTH].
- tag_in  in  TAG_WIDTH  sideband, passed through unchanged.
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream accepts the result.
- sum_out  out  PP_WIDTH  carry-save sum row.
- carry_out  out  PP_WIDTH  carry-save carry row, already shifted to its true weight.
- tag_out  out  TAG_WIDTH  tag of the result currently presented.

## Operation
- Reduction schedule is Dadda. Heights step down through 2, 3, 4, 6, 9, 13, 19.
- LEVELS is the number of 3:2 levels: 0 for NUM_PP=2, 1 for 3, 2 for 4, 3 for 5..6, 4 for 7..9, 5 for 10..13, 6 for 14..16.
- Each level is a row-wide array of full adders. Carries shift left by 1, and the bit shifted out of the MSB is discarded.
- All arithmetic is modulo 2^PP_WIDTH. The invariant is (sum_out + carry_out) mod 2^PP_WIDTH equals the sum of all rows mod 2^PP_WIDTH.
- carry_out[0] is always 0.
- Row contents are not interpreted as signed or unsigned. Sign extension is the generator's responsibility.
- Pipeline stages: STAGES = max(1, ceil(LEVELS/REG_EVERY)).
  - One register follows every REG_EVERY levels.
  - The final register drives the outputs. There is no combinational path from partial_products to sum_out or carry_out.
- Each stage holds a valid bit plus its intermediate rows and tag.
- Per-stage ready: ready_k = !valid_k || ready_(k+1), with ready_(STAGES) = out_ready.
  - in_ready = ready_0.
  - Bubbles collapse, so a stalled output does not block upstream stages that are empty.
- Transfers:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - When a stage is loaded, it takes the upstream data and valid together. When it is not loaded, it holds.
- Data and tag never change while out_valid=1 and out_ready=0.

## Timing
- Latency is STAGES cycles from the accepting edge to out_valid=1. With the defaults, STAGES=2.
- Throughput is one result per cycle while out_ready=1.
- Simultaneous input and output transfer on a full pipeline is allowed. in_ready is high in that case because out_ready propagates combinationally through the ready chain.
- Capacity is exactly STAGES sets in flight. When all are held, in_ready=0.
- Reset:
  - All valid bits clear.
  - All data and tag registers clear to 0.
  - After reset: out_valid=0, sum_out=0, carry_out=0, tag_out=0, in_ready=1 in the first cycle after rst deasserts.
- Reset asserted mid-stream discards every in-flight set. No output transfers occur while rst=1.
- in_valid is ignored during rst. in_ready may be high during reset, but no transfer counts.

## Structure
- Package csa_tree_pkg holds:
  - function dadda_levels(n) returning LEVELS;
  - function tree_stages(levels, reg_every) returning STAGES;
  - constant MAX_PP = 16.
- Sub-module csa_3to2 #(W): row-wide full-adder array. Inputs a, b, c; outputs s and c_shifted, where c_shifted = {maj[W-2:0], 1'b0}.
- The top level generates the levels and the stage registers. Configurations with NUM_PP outside 2..16 or REG_EVERY < 1 fail at elaboration.

## Test plan
- Defaults: rows 0x0001, 0x0002, 0x0004, 0x0008 with tag 0x5. Required: out_valid rises exactly 2 cycles after acceptance, sum_out + carry_out = 0x000F, tag_out = 0x5, carry_out[0] = 0.
- Wrap-around: four rows of 0xFFFF. Required: (sum_out + carry_out) mod 2^16 = 0xFFFC.
- Backpressure: stream 6 sets with out_ready=0 for 5 cycles. Required: exactly 2 accepted, in_ready=0 thereafter, output held stable. After release, all 6 results arrive in order with tags 0..5, with no loss and no duplicates.
- Continuous stream of 100 random sets with out_ready=1. Required: one result per cycle after the 2-cycle fill, and every result satisfies the invariant.
- Reset mid-stream with 2 sets in flight. Required: the next cycle shows out_valid=0 with all outputs 0, and the first result after reset belongs to the first set accepted after reset.
- Configuration NUM_PP=8, REG_EVERY=3 (LEVELS=4, STAGES=2) and configuration NUM_PP=2 (STAGES=1). Required: latencies of 2 and 1 respectively, and 500 random sets each satisfy the invariant.
